// File: rtl/mp_mac_row.sv
// Multi-precision multiply-accumulate row: R = A*b + C + d, streamed one word per beat.
// Emits len+1 result words LSW first; the top word is the final high half plus carry.
module mp_mac_row #(
  parameter int unsigned W       = 64,
  parameter int unsigned N_MAX   = 32,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned LW      = $clog2(N_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  d,
  input  logic [LW-1:0] len,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  c,
  output logic          r_valid,
  output logic [W-1:0]  r,
  output logic          r_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e state_q, state_d;

  logic [W-1:0]   b_q;
  logic [LW-1:0]  len_q, in_cnt_q, out_cnt_q, len_eff;
  logic [W-1:0]   hi_q;
  logic           cy_q;
  logic           busy_q;
  logic [2*W-1:0] p_q [MUL_LAT];
  logic           v_q [MUL_LAT];

  logic [W-1:0] r_q, r_d;
  logic         r_valid_q, r_valid_d, r_last_q, r_last_d, done_q, done_d;

  logic           start_ok, accept, acc_v, last_acc;
  logic [2*W-1:0] prod, p_acc;
  logic [W:0]     sum, fin;

  assign len_eff  = (len > LW'(N_MAX)) ? LW'(N_MAX) : len;
  // Start is ignored for the whole command, including its done cycle.
  assign start_ok = start && (state_q == StIdle) && !busy_q && !done_q;
  assign a_ready  = (state_q == StRun) && (in_cnt_q < len_q);
  assign accept   = a_valid && a_ready;

  assign prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b_q} + {{W{1'b0}}, c};
  assign p_acc = p_q[MUL_LAT-1];
  assign acc_v = v_q[MUL_LAT-1] && (state_q == StRun);
  assign last_acc = acc_v && (out_cnt_q == len_q - LW'(1));

  assign sum = {1'b0, p_acc[W-1:0]} + {1'b0, hi_q} + {{W{1'b0}}, cy_q};
  assign fin = {1'b0, hi_q} + {{W{1'b0}}, cy_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok && (len_eff != '0)) state_d = StRun;
      StRun:   if (last_acc) state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next-state
  always_comb begin
    r_d       = r_q;
    r_valid_d = 1'b0;
    r_last_d  = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok && (len_eff == '0)) begin
          r_d       = d;
          r_valid_d = 1'b1;
          r_last_d  = 1'b1;
          done_d    = 1'b1;
        end
      end
      StRun: begin
        if (acc_v) begin
          r_d       = sum[W-1:0];
          r_valid_d = 1'b1;
        end
      end
      StFlush: begin
        r_d       = fin[W-1:0];
        r_valid_d = 1'b1;
        r_last_d  = 1'b1;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      b_q       <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      cy_q      <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        p_q[i] <= '0;
        v_q[i] <= 1'b0;
      end
    end else begin
      r_q       <= r_d;
      r_valid_q <= r_valid_d;
      r_last_q  <= r_last_d;
      done_q    <= done_d;

      if (start_ok && (len_eff != '0)) busy_q <= 1'b1;
      else if (done_q)                 busy_q <= 1'b0;

      if (start_ok) begin
        b_q       <= b;
        len_q     <= len_eff;
        hi_q      <= d;
        cy_q      <= 1'b0;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (accept) in_cnt_q <= in_cnt_q + LW'(1);
        if (acc_v) begin
          hi_q      <= p_acc[2*W-1:W];
          cy_q      <= sum[W];
          out_cnt_q <= out_cnt_q + LW'(1);
        end
      end

      // Valid tag travels alongside its product
      v_q[0] <= accept;
      if (accept) p_q[0] <= prod;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        v_q[i] <= v_q[i-1];
        p_q[i] <= p_q[i-1];
      end
    end
  end

  // The top word cannot overflow when A*b + C + d fits in len+1 words.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == StFlush)) assert (!fin[W]);
  end

  assign r_valid = r_valid_q;
  assign r       = r_q;
  assign r_last  = r_last_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mp_mac_row.sv
// Directed bench for mp_mac_row: hand-computed rows, gaps, reset abort, start masking.
module tb_mp_mac_row;
  localparam int W       = 64;
  localparam int N_MAX   = 32;
  localparam int MUL_LAT = 2;
  localparam int LW      = $clog2(N_MAX + 1);
  localparam logic [W-1:0] M = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  b = '0, d = '0, a = '0, c = '0;
  logic [LW-1:0] len = '0;
  logic          a_valid = 1'b0;
  logic          a_ready, r_valid, r_last, busy, done;
  logic [W-1:0]  r;

  mp_mac_row #(.W(W), .N_MAX(N_MAX), .MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .b       (b),
    .d       (d),
    .len     (len),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a       (a),
    .c       (c),
    .r_valid (r_valid),
    .r       (r),
    .r_last  (r_last),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] oq[$];
  bit           lq[$];
  bit           dq[$];
  int           tq[$];
  always @(negedge clk) begin
    if (r_valid) begin
      oq.push_back(r);
      lq.push_back(r_last);
      dq.push_back(done);
      tq.push_back(cyc);
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] av[40], cv[40], ex[41];
  int           in_t[40];

  task automatic run_row(input string nm, input logic [W-1:0] bb, input logic [W-1:0] dd,
                         input int n, input int n_eff, input int gap_at, input bit poke);
    int k;
    oq.delete(); lq.delete(); dq.delete(); tq.delete();
    @(negedge clk);
    start = 1'b1; b = bb; d = dd; len = LW'(n);
    @(negedge clk);
    start = 1'b0;
    check({nm, ".busy"}, W'(busy), W'(n_eff > 0));
    if (n_eff == 0) check({nm, ".a_ready0"}, W'(a_ready), '0);
    for (int i = 0; i < n_eff; i++) begin
      if (i == gap_at) begin
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      a_valid = 1'b1; a = av[i]; c = cv[i];
      if (poke && i == 1) begin
        start = 1'b1; b = 64'h99;
      end
      k = 0;
      while (!a_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      check({nm, ".a_ready"}, W'(a_ready), 1);
      in_t[i] = cyc;
      @(negedge clk);
      start = 1'b0;
    end
    a_valid = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({nm, ".done_seen"}, W'(done), 1);
    @(posedge clk);
    #1;
    check({nm, ".beats"}, W'(oq.size()), W'(n_eff + 1));
    if (oq.size() == n_eff + 1) begin
      for (int j = 0; j <= n_eff; j++) begin
        check($sformatf("%s.r[%0d]", nm, j), oq[j], ex[j]);
        check($sformatf("%s.last[%0d]", nm, j), W'(lq[j]), W'(j == n_eff));
        check($sformatf("%s.done[%0d]", nm, j), W'(dq[j]), W'(j == n_eff));
      end
      for (int j = 0; j < n_eff; j++)
        check($sformatf("%s.lat[%0d]", nm, j), W'(tq[j] - in_t[j]), W'(MUL_LAT + 1));
      if (n_eff > 0)
        check({nm, ".final_next"}, W'(tq[n_eff] - tq[n_eff-1]), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check("rst.r_valid", W'(r_valid), 0);
    check("rst.r", r, 0);
    check("rst.ctl", W'({r_last, done, busy, a_ready}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3*7 + 11 + 5 = 37, top word 0
    av[0] = 7; cv[0] = 11; ex[0] = 37; ex[1] = 0;
    run_row("basic", 3, 5, 1, 1, -1, 0);

    // (2^128-1)(2^64-1) + (2^128-1) + (2^64-1) = 2^192-1
    av[0] = M; av[1] = M; cv[0] = M; cv[1] = M;
    ex[0] = M; ex[1] = M; ex[2] = M;
    run_row("ones", M, M, 2, 2, -1, 0);

    // 1*1 + 0 + (2^64-1) = 2^64: low word wraps, carry into the top word
    av[0] = 1; cv[0] = 0; ex[0] = 0; ex[1] = 1;
    run_row("carry", 1, M, 1, 1, -1, 0);

    ex[0] = 64'h1234;
    run_row("zero_len", 2, 64'h1234, 0, 0, -1, 0);

    // A = {2^63, 1, 2^63+1, 5}, C = {3, 0, 0, 2^64-1}, b = 2, d = 1
    av[0] = 64'h8000_0000_0000_0000; av[1] = 1; av[2] = 64'h8000_0000_0000_0001; av[3] = 5;
    cv[0] = 3; cv[1] = 0; cv[2] = 0; cv[3] = M;
    ex[0] = 4; ex[1] = 3; ex[2] = 2; ex[3] = 10; ex[4] = 1;
    run_row("gapped", 2, 1, 4, 4, 2, 0);

    // Start mid-row with b=0x99 must be ignored
    av[0] = 1; av[1] = 2; cv[0] = 0; cv[1] = 0;
    ex[0] = 5; ex[1] = 10; ex[2] = 0;
    run_row("poke", 5, 0, 2, 2, -1, 1);

    // len above N_MAX clamps to N_MAX words
    for (int i = 0; i < 40; i++) begin
      av[i] = 1; cv[i] = 0; ex[i] = 1;
    end
    ex[N_MAX] = 0;
    run_row("clamp", 1, 0, 40, N_MAX, -1, 0);

    // Start during the done cycle is ignored, one cycle later it is taken
    @(negedge clk);
    start = 1'b1; b = 1; d = 0; len = 1;
    @(negedge clk);
    start = 1'b0; a_valid = 1'b1; a = 1; c = 0;
    @(negedge clk);
    a_valid = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("dc.done_seen", W'(done), 1);
    start = 1'b1; len = 0; d = 64'h77;
    @(negedge clk);
    start = 1'b0;
    check("dc.ignored", W'(r_valid), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("dc.taken_valid", W'(r_valid), 1);
    check("dc.taken_r", r, 64'h77);

    // Reset in the middle of a len=8 row
    @(negedge clk);
    oq.delete();
    start = 1'b1; b = 1; d = 0; len = 8;
    @(negedge clk);
    start = 1'b0; a_valid = 1'b1; a = 1; c = 0;
    k = 0;
    while (oq.size() < 2 && k < 50) begin
      @(negedge clk);
      a = a + 1;
      k++;
    end
    check("rr.two_out", W'(oq.size() >= 2), 1);
    rst_n = 1'b0;
    a_valid = 1'b0;
    #1;
    check("rr.r_valid", W'(r_valid), 0);
    check("rr.r", r, 0);
    check("rr.ctl", W'({r_last, done, busy, a_ready}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    oq.delete();
    repeat (20) @(negedge clk);
    check("rr.silent", W'(oq.size()), 0);

    av[0] = 7; cv[0] = 11; ex[0] = 37; ex[1] = 0;
    run_row("after_rst", 3, 5, 1, 1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
